// File: rtl/multiplier_pkg.sv
// multiplier_pkg: mode and state encodings plus iteration-count helper for iterative_multiplier
package multiplier_pkg;
  typedef enum logic [1:0] {MODE_MUL = 2'b00, MODE_MULH = 2'b01, MODE_MULHSU = 2'b10, MODE_MULHU = 2'b11} mode_e;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;
  function automatic int n_iter(input int width, input int digit);
    return width / digit;
  endfunction
endpackage

// File: rtl/digit_multiplier.sv
// digit_multiplier: combinational unsigned WIDTH x DIGIT partial product
module digit_multiplier #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic [WIDTH-1:0]       a,
  input  logic [DIGIT-1:0]       b,
  output logic [WIDTH+DIGIT-1:0] p
);
  always_comb p = (WIDTH+DIGIT)'(a) * (WIDTH+DIGIT)'(b);
endmodule

// File: rtl/iterative_multiplier.sv
// iterative_multiplier: multi-cycle RISC-V MUL/MULH/MULHSU/MULHU, DIGIT multiplier bits per cycle; define ITERATIVE_MULTIPLIER_EARLY_EXIT_EN to leave CALC once the multiplier is exhausted
module iterative_multiplier
  import multiplier_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int N = n_iter(WIDTH, DIGIT);
  localparam int CW = $clog2(N + 1);
`ifdef ITERATIVE_MULTIPLIER_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  if (WIDTH % DIGIT != 0) begin : g_digit_check
    $error("WIDTH must be a multiple of DIGIT");
  end
  state_e state_q, state_d;
  mode_e mode_q, mode_d, mode_in;
  logic neg_q, neg_d, done_q, done_d, s1, s2;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, product_q, product_d, mag1, mag2;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0] iter_q, iter_d;
  logic [WIDTH+DIGIT-1:0] pp;
  digit_multiplier #(.WIDTH(WIDTH), .DIGIT(DIGIT)) u_digit (
    .a(mcand_q),
    .b(mplier_q[DIGIT-1:0]),
    .p(pp)
  );
  always_comb begin
    mode_in = mode_e'(mode);
    s1 = (mode_in == MODE_MULH || mode_in == MODE_MULHSU) && operand_1[WIDTH-1];
    s2 = mode_in == MODE_MULH && operand_2[WIDTH-1];
    mag1 = s1 ? -operand_1 : operand_1;
    mag2 = s2 ? -operand_2 : operand_2;
    state_d = state_q;
    mode_d = mode_q;
    neg_d = neg_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    acc_d = acc_q;
    iter_d = iter_q;
    product_d = product_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        mode_d = mode_in;
        neg_d = s1 ^ s2;
        mcand_d = mag1;
        mplier_d = mag2;
        acc_d = '0;
        iter_d = '0;
        state_d = (EARLY && mag2 == '0) ? S_FIX : S_CALC;
      end
      S_CALC: begin
        acc_d = acc_q + ((2*WIDTH)'(pp) << (DIGIT * iter_q));
        mplier_d = mplier_q >> DIGIT;
        iter_d = iter_q + CW'(1);
        state_d = (iter_q == CW'(N - 1) || (EARLY && mplier_d == '0)) ? S_FIX : S_CALC;
      end
      S_FIX: begin
        acc_d = neg_q ? -acc_q : acc_q;
        state_d = S_DONE;
      end
      default: begin
        product_d = mode_q == MODE_MUL ? acc_q[WIDTH-1:0] : acc_q[2*WIDTH-1:WIDTH];
        done_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      mode_q <= MODE_MUL;
      neg_q <= 1'b0;
      mcand_q <= '0;
      mplier_q <= '0;
      acc_q <= '0;
      iter_q <= '0;
      product_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      neg_q <= neg_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      acc_q <= acc_d;
      iter_q <= iter_d;
      product_q <= product_d;
      done_q <= done_d;
    end
  end
  assign busy = state_q != S_IDLE;
  assign done = done_q;
  assign product = product_q;
endmodule

// File: tb/tb_iterative_multiplier.sv
// tb_iterative_multiplier: table, corner-sequence and random checks of iterative_multiplier against a 64-bit reference
module tb_iterative_multiplier;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, busy, done;
  logic [1:0] mode = 2'b00;
  logic [31:0] operand_1 = '0, operand_2 = '0, product;
  int n_vec = 0, n_err = 0;

  iterative_multiplier dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .operand_1(operand_1), .operand_2(operand_2),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  m;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
  } vec_t;

  function automatic logic [31:0] ref_mul(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] x, y, p;
    x = (m == 2'b01 || m == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
    y = (m == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    p = x * y;
    return m == 2'b00 ? p[31:0] : p[63:32];
  endfunction

  function automatic int exp_lat(input logic [1:0] m, input logic [31:0] b);
    logic [31:0] mag;
    int d;
    mag = (m == 2'b01 && b[31]) ? -b : b;
    d = 4;
`ifdef ITERATIVE_MULTIPLIER_EARLY_EXIT_EN
    d = 0;
    for (int i = 0; i < 4; i++) if (mag[8*i +: 8] != 8'h00) d = i + 1;
`endif
    return d + 2;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input int start_cnt, output int cnt);
    cnt = start_cnt;
    while (!done && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
  endtask

  task automatic run_op(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ep, input string tag);
    int cnt;
    mode = m; operand_1 = a; operand_2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mode = 2'($urandom); operand_1 = $urandom; operand_2 = $urandom;
    check({tag, " busy"}, 64'(busy), 64'd1);
    wait_done(0, cnt);
    check({tag, " latency"}, 64'(cnt), 64'(exp_lat(m, b)));
    check({tag, " product"}, 64'(product), 64'(ep));
    @(posedge clk); #1;
    check({tag, " pulse"}, 64'(done), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] edges [5];
    edges = '{32'h0, 32'h1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 255));
      2: return edges[$urandom_range(0, 4)];
      default: return $urandom >> $urandom_range(0, 31);
    endcase
  endfunction

  initial begin
    vec_t tbl [12];
    int cnt, el, extra;
    logic [1:0] m;
    logic [31:0] a, b;
    tbl = '{
      '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001},
      '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
      '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF},
      '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
      '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
      '{2'b00, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A},
      '{2'b01, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000},
      '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
      '{2'b01, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF},
      '{2'b00, 32'h1234_5678, 32'h0000_0003, 32'h369D_0368},
      '{2'b11, 32'h1234_5678, 32'h0000_0003, 32'h0000_0000},
      '{2'b11, 32'h0000_1234, 32'h0000_0000, 32'h0000_0000}
    };
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset product", 64'(product), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) run_op(tbl[i].m, tbl[i].a, tbl[i].b, tbl[i].p, $sformatf("table%0d", i));

    mode = 2'b00; operand_1 = 32'd5; operand_2 = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    mode = 2'b11; operand_1 = 32'hFFFF; operand_2 = 32'hFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(2, cnt);
    check("repulse latency", 64'(cnt), 64'(exp_lat(2'b00, 32'd5)));
    check("repulse product", 64'(product), 64'd25);
    extra = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    check("repulse no second op", 64'(extra), 64'd0);

    el = exp_lat(2'b00, 32'd13);
    mode = 2'b00; operand_1 = 32'd11; operand_2 = 32'd13; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (el - 1) begin
      @(posedge clk); #1;
    end
    mode = 2'b11; operand_1 = 32'hFFFF_FFFF; operand_2 = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("done-cycle done", 64'(done), 64'd1);
    check("done-cycle product", 64'(product), 64'd143);
    check("done-cycle start ignored", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check("done-cycle still idle", 64'(busy), 64'd0);

    mode = 2'b00; operand_1 = 32'd3; operand_2 = 32'h0909_0909; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort product", 64'(product), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("abort no done", 64'(done), 64'd0);
    run_op(2'b00, 32'd7, 32'd6, 32'h0000_002A, "after abort");

    for (int i = 0; i < 1500; i++) begin
      m = 2'($urandom);
      a = pick();
      b = pick();
      run_op(m, a, b, ref_mul(m, a, b), $sformatf("rand%0d m%0d %h*%h", i, m, a, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
